bram_rd_streamer: RTL
=====================

// Module: bram_rd_streamer
// PURPOSE
//  Read-side master for an sdp_bwe_bram instance. Accepts a (start address, length) command, issues
//  sequential reads on the BRAM read port (addrb/enb/regceb), realigns the fixed read latency and
//  delivers the words as a valid/ready stream with a last flag. A credit-limited skid FIFO absorbs
//  in-flight data so the stream tolerates arbitrary back-pressure without losing or duplicating words.
// PARAMETERS
//  DATA_WIDTH  64  width of a BRAM word and of m_data (NB_COL*COL_WIDTH of the attached BRAM)
//  ADDR_WIDTH  9   BRAM address width (clogb2(RAM_DEPTH-1))
//  LEN_WIDTH   10  width of cmd_len
//  RD_LATENCY  2   BRAM read latency: 2 = HIGH_PERFORMANCE, 1 = LOW_LATENCY; other values illegal
//  FIFO_DEPTH  4   skid FIFO entries; >= RD_LATENCY+2 for full throughput, must be >= RD_LATENCY+1
// PORTS
//  clk          in   1           clock
//  rstn         in   1           asynchronous active-low reset
//  cmd_valid    in   1           command request
//  cmd_ready    out  1           command accepted when cmd_valid & cmd_ready
//  cmd_addr     in   ADDR_WIDTH  first word address
//  cmd_len      in   LEN_WIDTH   number of words minus 1 (0 = one word)
//  bram_addrb   out  ADDR_WIDTH  BRAM read address
//  bram_enb     out  1           BRAM read enable (one read per high cycle)
//  bram_regceb  out  1           BRAM output-register enable (RD_LATENCY=2 only; else tied 0)
//  bram_doutb   in   DATA_WIDTH  BRAM read data
//  m_valid      out  1           stream word valid
//  m_ready      in   1           stream sink ready
//  m_data       out  DATA_WIDTH  stream word
//  m_last       out  1           marks final word of the command
//  busy         out  1           high from command acceptance until the last word is transferred
// BEHAVIOUR
//  Reset (async assert, sync release): state IDLE; cmd_ready=1; bram_enb=0, bram_regceb=0,
//   bram_addrb=0; m_valid=0, m_last=0, m_data=0; busy=0; FIFO, credit and latency pipeline cleared.
//  FSM: IDLE -> RUN on cmd handshake (latch addr, len); RUN -> DRAIN after the read with remaining
//   count 0 is issued; DRAIN -> IDLE on the handshake of the word with m_last=1. cmd_ready=1 only in IDLE.
//  Issue rule (RUN): bram_enb=1 iff fifo_count + inflight < FIFO_DEPTH; inflight = reads issued whose
//   data has not yet been written to the FIFO. Each issued read post-increments bram_addrb and
//   decrements the remaining count. Addresses wrap modulo 2^ADDR_WIDTH.
//  Latency pipeline: RD_LATENCY-deep shift register of {valid,last}. bram_regceb = stage-0 valid
//   (RD_LATENCY=2). The word read in cycle c is sampled from bram_doutb in cycle c+RD_LATENCY and
//   pushed into the FIFO at the end of that cycle; m_valid first rises in cycle c+RD_LATENCY+1.
//  Stream: m_valid = FIFO not empty; m_data/m_last = FIFO head; pop on m_valid & m_ready.
//   m_data/m_last stable while m_valid & !m_ready. Push and pop in the same cycle keep count unchanged.
//  Throughput: with m_ready held 1 and default parameters, one word per cycle after initial latency.
//  FIFO overflow is impossible by the credit rule; a push into a full FIFO is a design error (assert).
//  cmd_len max: 2^LEN_WIDTH words per command; cmd_valid while not IDLE is held off (no queueing).
//  Reset mid-operation: everything above returns to reset values immediately; in-flight BRAM data is
//   discarded (valid bits cleared); BRAM contents untouched.
// TESTING
//  1 addr=0x010, len=7, m_ready=1, BRAM[i]=i -> 8 words 0x10..0x17 back-to-back, m_last on 0x17 only,
//    first m_valid 3 cycles after first bram_enb; busy falls the cycle after last handshake.
//  2 addr=0x1FE, len=3 (ADDR_WIDTH=9) -> bram_addrb 0x1FE,0x1FF,0x000,0x001; data in that order.
//  3 len=15, m_ready toggled randomly 30% duty -> all 16 words in order, none lost/duplicated,
//    bram_enb never high when fifo_count+inflight=4, FIFO never overflows (assertion).
//  4 m_ready=0 for 20 cycles after accept, len=9 -> exactly 4 reads issued then stall; resume m_ready=1
//    -> remaining 6 reads issued, 10 words delivered, m_data stable while stalled.
//  5 cmd_valid held during RUN -> cmd_ready=0 until IDLE; second command then accepted, runs correctly;
//    len=0 -> single word with m_last=1.
//  6 rstn pulsed low mid-stream (cycle 5 of len=31) -> outputs at reset values asynchronously; a new
//    command after release streams correctly with no stale words from the aborted command.

Source files
------------

// File: rtl/bram_rd_streamer_if.sv
// Bus bundle for the BRAM read streamer: command channel, BRAM read port and output stream.
// master = the streamer, slave = whatever drives commands, owns the BRAM and sinks the stream.
interface bram_rd_streamer_if #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 9,
  parameter int LEN_WIDTH  = 10
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [LEN_WIDTH-1:0]  cmd_len;
  logic [ADDR_WIDTH-1:0] bram_addrb;
  logic                  bram_enb;
  logic                  bram_regceb;
  logic [DATA_WIDTH-1:0] bram_doutb;
  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_last;

  modport master (
    input  cmd_valid, cmd_addr, cmd_len, bram_doutb, m_ready,
    output cmd_ready, bram_addrb, bram_enb, bram_regceb, m_valid, m_data, m_last
  );
  modport slave (
    output cmd_valid, cmd_addr, cmd_len, bram_doutb, m_ready,
    input  cmd_ready, bram_addrb, bram_enb, bram_regceb, m_valid, m_data, m_last
  );
endinterface

// File: rtl/bram_rd_streamer.sv
// Sequential BRAM reader: turns (addr, len) commands into a valid/ready stream with m_last.
// Reads are only issued while the skid FIFO has room for every word already in flight.
module bram_rd_streamer #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 9,
  parameter int LEN_WIDTH  = 10,
  parameter int RD_LATENCY = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rstn,
  bram_rd_streamer_if.master  bus,
  output logic                busy
);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LEN_WIDTH-1:0]  rem_q;
  logic [RD_LATENCY-1:0] vld_pipe_q, last_pipe_q;
  logic [DATA_WIDTH-1:0] data_mem_q [FIFO_DEPTH];
  logic                  last_mem_q [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]         cnt_q;

  int unsigned inflight;
  logic        credit_ok, issue, push, pop;

  always_comb begin
    inflight = 0;
    for (int i = 0; i < RD_LATENCY; i++) inflight += 32'(vld_pipe_q[i]);
  end

  assign credit_ok = (32'(cnt_q) + inflight) < 32'(FIFO_DEPTH);
  assign issue     = (state_q == RUN) && credit_ok;
  assign push      = vld_pipe_q[RD_LATENCY-1];
  assign pop       = bus.m_valid && bus.m_ready;

  assign bus.cmd_ready  = (state_q == IDLE);
  assign busy           = (state_q != IDLE);
  assign bus.bram_enb   = issue;
  assign bus.bram_addrb = addr_q;
  assign bus.m_valid    = (cnt_q != '0);
  assign bus.m_data     = data_mem_q[rd_ptr_q];
  assign bus.m_last     = bus.m_valid && last_mem_q[rd_ptr_q];

  // The output register only needs clocking in the cycle after a read was issued.
  generate
    if (RD_LATENCY == 2) begin : g_regce
      assign bus.bram_regceb = vld_pipe_q[0];
    end else begin : g_noregce
      assign bus.bram_regceb = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
    end else begin
      case (state_q)
        IDLE: if (bus.cmd_valid) begin
          addr_q  <= bus.cmd_addr;
          rem_q   <= bus.cmd_len;
          state_q <= RUN;
        end
        RUN: if (issue) begin
          addr_q <= addr_q + 1'b1;
          rem_q  <= rem_q - 1'b1;
          if (rem_q == '0) state_q <= DRAIN;
        end
        DRAIN: if (pop && bus.m_last) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // {valid,last} travel alongside the read so the FIFO knows which BRAM cycle carries data.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld_pipe_q  <= '0;
      last_pipe_q <= '0;
    end else begin
      vld_pipe_q[0]  <= issue;
      last_pipe_q[0] <= issue && (rem_q == '0);
      for (int i = 1; i < RD_LATENCY; i++) begin
        vld_pipe_q[i]  <= vld_pipe_q[i-1];
        last_pipe_q[i] <= last_pipe_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        data_mem_q[i] <= '0;
        last_mem_q[i] <= 1'b0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) begin
        data_mem_q[wr_ptr_q] <= bus.bram_doutb;
        last_mem_q[wr_ptr_q] <= last_pipe_q[RD_LATENCY-1];
        wr_ptr_q <= (wr_ptr_q == PW'(FIFO_DEPTH-1)) ? '0 : wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= (rd_ptr_q == PW'(FIFO_DEPTH-1)) ? '0 : rd_ptr_q + 1'b1;
      cnt_q <= cnt_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rstn) assert (!(push && cnt_q == CW'(FIFO_DEPTH)));
  end
endmodule
